apo_inject_scheduler_5: RTL

APO_INJECT_SCHEDULER_5 -- requirements
Module: apo_inject_scheduler_5

---
 rtl/apo_inject_scheduler_5.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apo_inject_scheduler_5.sv
// Five-router injection scheduler: one pending slot per router, round-robin grant,
// per-router cooldown after each injection, registered one-cycle output packets.
module apo_inject_scheduler_5 #(
  parameter int N2       = 7,
  parameter int COOLDOWN = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_en,
  input  logic             req_valid,
  input  logic [2:0]       req_router,
  input  logic [N2-2:0]    req_data,
  output logic             req_ready,
  output logic [N2-1:0]    out_router1,
  output logic [N2-1:0]    out_router2,
  output logic [N2-1:0]    out_router3,
  output logic [N2-1:0]    out_router4,
  output logic [N2-1:0]    out_router5,
  output logic             busy,
  output logic [CNT_W-1:0] inj_count,
  output logic             err_bad_router
);

  localparam int NR   = 5;
  localparam int DW   = N2 - 1;
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [NR-1:0]   pending;
  logic [DW-1:0]   data_q   [NR];
  logic [CD_W-1:0] cooldown [NR];
  logic [N2-1:0]   out_q    [NR];
  logic [2:0]      rr;

  logic            req_in_range;
  logic            slot_busy;
  logic            accept;
  logic [NR-1:0]   eligible;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic [2:0]      rr_next;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    req_in_range = (req_router < 3'(NR));
    slot_busy    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (req_router == 3'(i)) slot_busy = pending[i];
    end
    req_ready = !req_in_range || !slot_busy;
    accept    = req_valid && req_ready && req_in_range;
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      eligible[i] = pending[i] && (cooldown[i] == '0) && sched_en;
    end
  end

  // First eligible router at or after rr, wrapping modulo NR.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NR; k++) begin
      cand = (int'(rr) + k) % NR;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(cand);
      end
    end
    rr_next = (grant_idx == 3'(NR - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  always_comb begin
    busy = |pending;
    for (int i = 0; i < NR; i++) begin
      if (cooldown[i] != '0) busy = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= '0;
      rr             <= '0;
      inj_count      <= '0;
      err_bad_router <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        cooldown[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      err_bad_router <= req_valid && !req_in_range;
      for (int i = 0; i < NR; i++) begin
        if (grant_valid && grant_idx == 3'(i)) begin
          out_q[i]    <= {1'b1, data_q[i]};
          cooldown[i] <= CD_LOAD;
          pending[i]  <= 1'b0;
        end else begin
          out_q[i] <= '0;
          if (cooldown[i] != '0) cooldown[i] <= cooldown[i] - CD_W'(1);
          // A pending slot refuses new requests, so accept never meets grant here.
          if (accept && req_router == 3'(i)) pending[i] <= 1'b1;
        end
      end
      if (grant_valid) begin
        rr        <= rr_next;
        inj_count <= inj_count + CNT_W'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; it is only read while its pending flag
  // is set, and that flag is always written together with the data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (accept && req_router == 3'(i)) data_q[i] <= req_data;
    end
  end

  assign out_router1 = out_q[0];
  assign out_router2 = out_q[1];
  assign out_router3 = out_q[2];
  assign out_router4 = out_q[3];
  assign out_router5 = out_q[4];

endmodule
